// File: rtl/ntr_pkg.sv
// Shared definitions for the NTR reply path: opcodes, reply lengths,
// controller state encoding and the reply-source classification.
package ntr_pkg;

  localparam logic [7:0] OP_DUMMY  = 8'h9F;
  localparam logic [7:0] OP_HEADER = 8'h00;
  localparam logic [7:0] OP_CHIPID = 8'h90;
  localparam logic [7:0] OP_READ   = 8'hB7;

  localparam logic [13:0] LEN_DUMMY = 14'h2000;
  localparam logic [13:0] LEN_BLOCK = 14'h200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_FETCH,
    ST_PRESENT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  // Where reply bytes come from: nowhere, constant 0xFF, the ROM port, or CHIP_ID.
  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_FILL,
    KIND_ROM,
    KIND_ID
  } kind_t;

  // Chip ID goes out least-significant byte first, repeating every four bytes.
  function automatic logic [7:0] chip_id_byte(input logic [31:0] id, input logic [1:0] sel);
    return id[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ntr_cmd_decode.sv
// Combinational opcode decoder: classifies the captured command and yields
// the reply source, ROM base address and reply length.
module ntr_cmd_decode
  import ntr_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic [63:0]       command,
  output logic [1:0]        kind,
  output logic [ADDR_W-1:0] base,
  output logic [13:0]       len
);

  logic [31:0] addr32;
  logic        unused_cmd_bits;

  // Address field of a data read; bits above ADDR_W are dropped.
  assign addr32          = command[55:24];
  assign unused_cmd_bits = ^{command[23:0], addr32};

  // Opcode lookup; unknown opcodes produce an empty reply.
  always_comb begin
    kind = KIND_NONE;
    base = '0;
    len  = '0;
    case (command[63:56])
      OP_DUMMY: begin
        kind = KIND_FILL;
        len  = LEN_DUMMY;
      end
      OP_HEADER: begin
        kind = KIND_ROM;
        len  = LEN_BLOCK;
      end
      OP_CHIPID: begin
        kind = KIND_ID;
        len  = LEN_BLOCK;
      end
      OP_READ: begin
        kind = KIND_ROM;
        base = addr32[ADDR_W-1:0];
        len  = LEN_BLOCK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ntr_responder.sv
// NTR reply stage: decodes the captured command, fetches reply bytes over the
// ROM req/ack port and steps them onto the bus on each ntr_clk rising edge.
module ntr_responder
  import ntr_pkg::*;
#(
  parameter logic [31:0] CHIP_ID = 32'hC20F_0000,
  parameter int          ADDR_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ntr_clk,
  input  logic              ntr_cs1,
  input  logic [63:0]       command,
  input  logic              ready,
  output logic [7:0]        ntr_data_out,
  output logic              ntr_data_oe,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic              underrun
);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic              prev_q, prev_d;
  logic [13:0]       index_q, index_d;
  logic [13:0]       len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        data_q, data_d;
  logic              underrun_q, underrun_d;

  logic [1:0]        dec_kind;
  logic [ADDR_W-1:0] dec_base;
  logic [13:0]       dec_len;
  logic              rise;
  logic [14:0]       idx_inc;

  ntr_cmd_decode #(.ADDR_W(ADDR_W)) u_decode (
    .command (command),
    .kind    (dec_kind),
    .base    (dec_base),
    .len     (dec_len)
  );

  // Edge detect, next index (one bit wider so the end-of-reply compare cannot wrap) and ROM address.
  assign rise     = ntr_clk & ~prev_q;
  assign prev_d   = ntr_clk;
  assign idx_inc  = {1'b0, index_q} + 15'd1;
  assign rom_addr = base_q + ADDR_W'(index_q);

  assign rom_req      = ((state_q == ST_FETCH) && (kind_q == KIND_ROM)) || (state_q == ST_DRAIN);
  assign ntr_data_oe  = (state_q == ST_FETCH) || (state_q == ST_PRESENT) || (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign ntr_data_out = data_q;
  assign underrun     = underrun_q;

  // Next-state logic; a pending ROM request is never abandoned on abort, it drains instead.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    index_d    = index_q;
    len_d      = len_q;
    base_d     = base_q;
    data_d     = data_q;
    underrun_d = underrun_q;
    case (state_q)
      ST_IDLE: begin
        if (ready && !ntr_cs1) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        kind_d  = kind_t'(dec_kind);
        base_d  = dec_base;
        len_d   = dec_len;
        index_d = '0;
        data_d  = 8'hFF;
        if (ntr_cs1)             state_d = ST_IDLE;
        else if (dec_len == '0)  state_d = ST_DONE;
        else                     state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Host clocked before the byte was ready: flag it and move on to the next index.
        if (rise) begin
          underrun_d = 1'b1;
          index_d    = idx_inc[13:0];
        end
        if (kind_q == KIND_ROM) begin
          if (rom_ack) begin
            data_d  = rom_data;
            state_d = ntr_cs1 ? ST_IDLE : ST_PRESENT;
          end else if (ntr_cs1) begin
            state_d = ST_DRAIN;
          end
        end else begin
          data_d  = (kind_q == KIND_ID) ? chip_id_byte(CHIP_ID, index_q[1:0]) : 8'hFF;
          state_d = ntr_cs1 ? ST_IDLE : ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ntr_cs1) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          index_d = idx_inc[13:0];
          if (idx_inc >= {1'b0, len_q}) begin
            state_d = ST_DONE;
            data_d  = 8'hFF;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        data_d = 8'hFF;
        if (ntr_cs1) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (rom_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_NONE;
      prev_q     <= 1'b1;
      index_q    <= '0;
      len_q      <= '0;
      base_q     <= '0;
      data_q     <= 8'hFF;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      prev_q     <= prev_d;
      index_q    <= index_d;
      len_q      <= len_d;
      base_q     <= base_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_ntr_responder.sv
// Scoreboard bench for ntr_responder: a host model clocks bytes out, a ROM
// model answers requests with a programmable latency.
module tb_ntr_responder;
  import ntr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ntr_clk = 1'b1;
  logic        ntr_cs1 = 1'b1;
  logic [63:0] command = '0;
  logic        ready = 1'b0;
  logic [7:0]  ntr_data_out;
  logic        ntr_data_oe;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [7:0]  rom_data = '0;
  logic        busy;
  logic        underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int rom_lat = 2;
  int rom_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] got_addr[$];

  ntr_responder #(.CHIP_ID(32'hC20F_0000), .ADDR_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .ntr_clk      (ntr_clk),
    .ntr_cs1      (ntr_cs1),
    .command      (command),
    .ready        (ready),
    .ntr_data_out (ntr_data_out),
    .ntr_data_oe  (ntr_data_oe),
    .rom_req      (rom_req),
    .rom_addr     (rom_addr),
    .rom_ack      (rom_ack),
    .rom_data     (rom_data),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  // ROM model: acks a held request after rom_lat cycles, single-cycle pulse.
  always @(negedge clk) begin
    if (rst) begin
      rom_ack = 1'b0;
      rom_cnt = 0;
    end else if (rom_ack) begin
      rom_ack = 1'b0;
      rom_cnt = 0;
    end else if (rom_req) begin
      rom_cnt++;
      if (rom_cnt >= rom_lat) begin
        rom_ack  = 1'b1;
        rom_data = rom_byte(rom_addr);
        got_addr.push_back(rom_addr);
      end
    end else begin
      rom_cnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [63:0] c);
    command = c;
    ntr_cs1 = 1'b0;
    ready   = 1'b1;
  endtask

  task automatic end_txn();
    ntr_cs1 = 1'b1;
    ready   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy) break;
    end
  endtask

  // Host: wait, sample the bus byte, then give one ntr_clk pulse.
  task automatic host_byte(input int w, output logic [7:0] d, output logic oe);
    repeat (w) tick();
    d  = ntr_data_out;
    oe = ntr_data_oe;
    ntr_clk = 1'b1;
    tick();
    ntr_clk = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (ntr_data_out !== 8'hFF) begin n_bad++; $display("FAIL reset_data: got %h want ff", ntr_data_out); end
    n_cmp++; if ({ntr_data_oe, rom_req, busy, underrun} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got oe/req/busy/ur=%b want 0000", {ntr_data_oe, rom_req, busy, underrun}); end
    n_cmp++; if (rom_addr !== 24'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 000000", rom_addr); end
    rst = 1'b0;
    tick();
    ntr_clk = 1'b0;
    tick();
  endtask

  task automatic test_dummy();
    logic [7:0] d;
    logic       oe;
    int         bad = 0;
    got_addr.delete();
    exp_q.delete();
    for (int i = 0; i < 'h2000; i++) exp_q.push_back(8'hFF);
    start_cmd(64'h9F00_0000_0000_0000);
    repeat (4) tick();
    for (int i = 0; i < 'h2000; i++) begin
      host_byte(2, d, oe);
      n_cmp++;
      if ({oe, d} !== {1'b1, exp_q.pop_front()}) begin
        n_bad++;
        if (bad++ < 8) $display("FAIL dummy_byte[%0d]: got %h oe %b want ff oe 1", i, d, oe);
      end
    end
    n_cmp++; if (dut.state_q !== ST_DONE) begin n_bad++; $display("FAIL dummy_done: got state %0d want %0d", dut.state_q, ST_DONE); end
    n_cmp++; if (got_addr.size() != 0) begin n_bad++; $display("FAIL dummy_norom: got %0d requests want 0", got_addr.size()); end
    end_txn();
    n_cmp++; if ({busy, ntr_data_oe} !== 2'b00) begin n_bad++; $display("FAIL dummy_idle: got busy/oe %b want 00", {busy, ntr_data_oe}); end
  endtask

  task automatic test_rom_read(input logic [63:0] cmd, input logic [23:0] base, input string name);
    logic [7:0]  d;
    logic        oe;
    logic [23:0] a;
    rom_lat = 2;
    got_addr.delete();
    exp_q.delete();
    for (int i = 0; i < 'h200; i++) begin
      a = base + 24'(i);
      exp_q.push_back(rom_byte(a));
    end
    start_cmd(cmd);
    repeat (4) tick();
    for (int i = 0; i < 'h200; i++) begin
      host_byte(rom_lat + 3, d, oe);
      a = base + 24'(i);
      n_cmp++;
      if ({oe, d} !== {1'b1, exp_q.pop_front()}) begin
        n_bad++;
        $display("FAIL %s_byte[%0d]: got %h oe %b want %h oe 1", name, i, d, oe, rom_byte(a));
      end
    end
    n_cmp++; if ({ntr_data_oe, ntr_data_out, rom_req} !== {1'b1, 8'hFF, 1'b0}) begin n_bad++; $display("FAIL %s_done: got oe %b data %h req %b want oe 1 data ff req 0", name, ntr_data_oe, ntr_data_out, rom_req); end
    n_cmp++; if (got_addr.size() != 'h200) begin n_bad++; $display("FAIL %s_reqcount: got %0d want 512", name, got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < 'h200; i++) begin
      a = base + 24'(i);
      n_cmp++;
      if (got_addr[i] !== a) begin n_bad++; $display("FAIL %s_addr[%0d]: got %h want %h", name, i, got_addr[i], a); end
    end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL %s_underrun: got %b want 0", name, underrun); end
    end_txn();
  endtask

  task automatic test_chip_id();
    logic [7:0] d;
    logic       oe;
    logic [7:0] id_bytes [4];
    id_bytes = '{8'h00, 8'h00, 8'h0F, 8'hC2};
    got_addr.delete();
    exp_q.delete();
    for (int i = 0; i < 'h200; i++) exp_q.push_back(id_bytes[i % 4]);
    start_cmd(64'h9000_0000_0000_0000);
    repeat (4) tick();
    for (int i = 0; i < 'h200; i++) begin
      host_byte(2, d, oe);
      n_cmp++;
      if ({oe, d} !== {1'b1, exp_q.pop_front()}) begin
        n_bad++;
        $display("FAIL chipid_byte[%0d]: got %h oe %b want %h oe 1", i, d, oe, id_bytes[i % 4]);
      end
    end
    tick();
    n_cmp++; if ({ntr_data_oe, ntr_data_out} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL chipid_tail: got oe %b data %h want oe 1 data ff", ntr_data_oe, ntr_data_out); end
    n_cmp++; if (got_addr.size() != 0) begin n_bad++; $display("FAIL chipid_norom: got %0d requests want 0", got_addr.size()); end
    end_txn();
  endtask

  task automatic test_abort();
    logic acked = 1'b0;
    rom_lat = 5;
    start_cmd(64'hB700_0123_4500_0000);
    for (int i = 0; i < 20; i++) begin
      if (rom_req) break;
      tick();
    end
    n_cmp++; if (rom_req !== 1'b1) begin n_bad++; $display("FAIL abort_req_start: got %b want 1", rom_req); end
    ntr_cs1 = 1'b1;
    ready   = 1'b0;
    for (int i = 0; i < 30 && !acked; i++) begin
      tick();
      if (rom_ack) begin
        acked = 1'b1;
      end else begin
        n_cmp++; if (rom_req !== 1'b1) begin n_bad++; $display("FAIL abort_req_held: got %b want 1", rom_req); end
      end
    end
    n_cmp++; if (!acked) begin n_bad++; $display("FAIL abort_ack_timeout: got no ack want ack"); end
    n_cmp++; if ({busy, ntr_data_oe} !== 2'b10) begin n_bad++; $display("FAIL abort_drain: got busy/oe %b want 10", {busy, ntr_data_oe}); end
    tick();
    n_cmp++; if ({busy, rom_req, ntr_data_oe} !== 3'b000) begin n_bad++; $display("FAIL abort_idle: got busy/req/oe %b want 000", {busy, rom_req, ntr_data_oe}); end
  endtask

  task automatic test_cs_priority();
    ntr_cs1 = 1'b1;
    ready   = 1'b1;
    command = 64'h9F00_0000_0000_0000;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cs_priority: got busy %b want 0", busy); end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_drain();
    rom_lat = 8;
    start_cmd(64'hB700_0000_1000_0000);
    for (int i = 0; i < 20; i++) begin
      if (rom_req) break;
      tick();
    end
    ntr_cs1 = 1'b1;
    ready   = 1'b0;
    repeat (2) tick();
    n_cmp++; if ({busy, rom_req} !== 2'b11) begin n_bad++; $display("FAIL drain_pre_rst: got busy/req %b want 11", {busy, rom_req}); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, rom_req} !== 2'b00) begin n_bad++; $display("FAIL drain_async_rst: got busy/req %b want 00", {busy, rom_req}); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_underrun();
    rom_lat = 10;
    start_cmd(64'hB700_0000_0100_0000);
    repeat (4) tick();
    for (int i = 0; i < 12; i++) begin
      ntr_clk = 1'b1;
      repeat (2) tick();
      ntr_clk = 1'b0;
      repeat (2) tick();
    end
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_set: got %b want 1", underrun); end
    end_txn();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL underrun_end: got busy %b want 0", busy); end
  endtask

  task automatic test_unknown_opcode();
    got_addr.delete();
    start_cmd(64'h3C00_0000_0000_0000);
    tick();
    n_cmp++; if ({busy, ntr_data_oe} !== 2'b10) begin n_bad++; $display("FAIL unk_decode: got busy/oe %b want 10", {busy, ntr_data_oe}); end
    tick();
    n_cmp++; if ({ntr_data_oe, ntr_data_out, rom_req} !== {1'b1, 8'hFF, 1'b0}) begin n_bad++; $display("FAIL unk_done: got oe %b data %h req %b want oe 1 data ff req 0", ntr_data_oe, ntr_data_out, rom_req); end
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
    repeat (4) tick();
    n_cmp++; if (got_addr.size() != 0) begin n_bad++; $display("FAIL unk_norom: got %0d requests want 0", got_addr.size()); end
    end_txn();
  endtask

  initial begin
    test_reset();
    test_dummy();
    test_rom_read(64'hB700_0123_4500_0000, 24'h012345, "read");
    test_rom_read(64'h0000_0000_0000_0000, 24'h000000, "header");
    test_rom_read(64'hB7AB_FFFF_0000_0000, 24'hFFFF00, "wrap");
    test_chip_id();
    test_abort();
    test_cs_priority();
    test_reset_in_drain();
    test_underrun();
    test_unknown_opcode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ntr_responder.md
# ntr_responder

Reply stage for the NTR cartridge bus. It sits directly downstream of the command capture stage and consumes that stage's 64-bit `command` and `ready` outputs. It decodes the opcode, fetches reply bytes from a byte-wide ROM port through a req/ack handshake, and presents them on the NTR data bus, advancing one byte per `ntr_clk` rising edge until `ntr_cs1` deasserts.

## Interface
- `CHIP_ID`, default 32'hC2_0F_00_00: value returned by opcode 0x90, sent LSB first and repeated.
- `ADDR_W`, default 24: ROM byte-address width.
- `clk` input 1: system clock; the same clock as the capture stage.
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `ntr_clk` input 1: NTR bus clock, sampled in the `clk` domain.
- `ntr_cs1` input 1: NTR chip select, active-low.
- `command` input 64: captured command. The first bus byte is `[63:56]`.
- `ready` input 1: command capture complete; held high until `ntr_cs1` rises.
- `ntr_data_out` output 8: reply byte.
- `ntr_data_oe` output 1: output enable for the bus driver.
- `rom_req` output 1: ROM read request.
- `rom_addr` output ADDR_W: ROM byte address.
- `rom_ack` input 1: one-cycle pulse; `rom_data` is valid in the same cycle.
- `rom_data` input 8: ROM byte.
- `busy` output 1: high in every state except IDLE.
- `underrun` output 1: sticky flag, cleared only by `rst`.

## Operation
- Opcode decode, from `command[63:56]`:
  - 0x9F (dummy): 0x2000 bytes of 0xFF, no ROM access.
  - 0x00 (header): 0x200 bytes from ROM address 0.
  - 0x90 (chip ID): 0x200 bytes, `CHIP_ID` bytes [7:0],[15:8],[23:16],[31:24], repeating.
  - 0xB7 (data read): 0x200 bytes from ROM address `command[55:24]` truncated to ADDR_W. Address wraps modulo 2^ADDR_W.
  - Any other opcode: reply length 0.
- States:
  - IDLE: wait for `ready`=1 and `ntr_cs1`=0, then go to DECODE.
  - DECODE: latch opcode, base address and length; clear the 14-bit byte index. Go to FETCH; go to DONE if length is 0.
  - FETCH:
    - ROM opcodes: `rom_req`=1 with `rom_addr`=base+index, held until `rom_ack`. Load `rom_data` into the output register, then go to PRESENT.
    - Non-ROM opcodes: load the byte and go to PRESENT after one cycle.
  - PRESENT: hold the byte. On an `ntr_clk` rising edge, increment the index. If index+1 equals length, go to DONE; otherwise go to FETCH.
  - DONE: drive 0xFF with `ntr_data_oe`=1 until `ntr_cs1` rises.
  - DRAIN: hold `rom_req` until `rom_ack`, discard the data, then go to IDLE.
- `ntr_data_oe`=1 in FETCH, PRESENT and DONE; 0 otherwise.
- Abort: `ntr_cs1`=1 in any state goes to IDLE next cycle. The exception is FETCH with `rom_req` outstanding and no `rom_ack` that cycle, which goes to DRAIN. `rom_req` is never dropped before `rom_ack`.
- Underrun: an `ntr_clk` rising edge while in FETCH sets `underrun`. The old byte stays on the bus, the index still increments, and the fetch in progress continues for the next byte.

## Timing
- Reset values:
  - Outputs: `ntr_data_out`=8'hFF; `ntr_data_oe`, `rom_req`, `busy`, `underrun`=0; `rom_addr`=0.
  - Internal: state=IDLE; `ntr_clk` history register=1, so a low-to-high level at reset exit is not treated as an edge.
- Edge detect: rising = `ntr_clk` & ~prev, where prev is a single register. The edge is acted on in the cycle it is detected.
- First byte latency:
  - `ready` seen in IDLE → DECODE → FETCH (`rom_req` asserted the cycle after DECODE).
  - The byte appears on `ntr_data_out` one cycle after `rom_ack`.
- Non-ROM first byte: valid 3 cycles after `ready` is sampled.
- Next byte: valid ROM latency+1 cycles after the `ntr_clk` edge. The host's `ntr_clk` high+low period must exceed this, or `underrun` sets.
- `ready` and `ntr_cs1` rise in the same cycle: `ntr_cs1` wins; stay in IDLE.
- `rst` during DRAIN: immediate IDLE. The ROM side must tolerate a dropped request on reset only.

## Structure
- Shared package `ntr_pkg`:
  - opcode constants OP_DUMMY, OP_HEADER, OP_CHIPID, OP_READ;
  - length constants LEN_DUMMY=14'h2000, LEN_BLOCK=14'h200;
  - the state encoding.
- One sub-module, `ntr_cmd_decode`: combinational; maps `command` to {kind, base address, length}.
- The byte index and address adder stay in the top.

## Test plan
- Command 0x9F00…, 0x2000 `ntr_clk` pulses → 0x2000 bytes of 0xFF; `rom_req` never asserted; state DONE after the last edge.
- Command 0xB7_00_01_23_45_…, ROM ack after 2 cycles → `rom_addr` sequence 0x012345, 0x012346, …, 0x012544; bytes match ROM; exactly 0x200 requests.
- Command 0x90…, `CHIP_ID`=32'hC2_0F_00_00 → bytes 00,00,0F,C2 repeating for 0x200 bytes, then 0xFF.
- `ntr_cs1` rises while `rom_req`=1 and ack is delayed 5 cycles → `rom_req` held to ack; `busy` falls the cycle after ack; `ntr_data_oe`=0.
- ROM latency 10 cycles with `ntr_clk` period 4 cycles → `underrun`=1 and stays 1 after a new command.
- Opcode 0x3C → `ntr_data_out`=0xFF with `ntr_data_oe`=1 immediately after DECODE; no ROM access.
